uart_recv: RTL and testbench

UART receive block: the serial-input counterpart of the team's UART transmitter. It samples the asynchronous `din` line with the same fixed baud timing (8N1, LSB first, 868 clocks per bit: 115200 baud at 100 MHz). Each correctly framed byte is presented on `din_data` together with a one-cycle `din_vld` strobe. The block sits between the board RX pin and downstream consumers (command parser, FIFO).

---
 rtl/uart_recv.sv | 139 +++++++++++++
 tb/tb_uart_recv.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_recv.sv
// UART receiver, 8N1, LSB first, fixed baud timing set by FULL_T/HALF_T.
// Define UART_RECV_FRAME_ERR_EN to add the frame_err pulse output.
module uart_recv #(
  parameter int FULL_T = 867,
  parameter int HALF_T = 433
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       din,
  output logic       din_vld,
  output logic [7:0] din_data
`ifdef UART_RECV_FRAME_ERR_EN
  ,
  output logic       frame_err
`endif
);

  localparam logic [9:0] FULL_C = 10'(FULL_T);
  localparam logic [9:0] HALF_C = 10'(HALF_T);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  logic       din_meta_reg;
  logic       din_s_reg;
  logic       din_d_reg;
  state_t     state_reg,   state_next;
  logic [9:0] div_cnt_reg, div_cnt_next;
  logic [2:0] bit_cnt_reg, bit_cnt_next;
  logic [7:0] shift_reg,   shift_next;
  logic [7:0] data_reg,    data_next;
  logic       vld_reg,     vld_next;
`ifdef UART_RECV_FRAME_ERR_EN
  logic       ferr_reg,    ferr_next;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      din_meta_reg <= 1'b1;
      din_s_reg    <= 1'b1;
      din_d_reg    <= 1'b1;
      state_reg    <= IDLE;
      div_cnt_reg  <= '0;
      bit_cnt_reg  <= '0;
      shift_reg    <= '0;
      data_reg     <= '0;
      vld_reg      <= 1'b0;
`ifdef UART_RECV_FRAME_ERR_EN
      ferr_reg     <= 1'b0;
`endif
    end else begin
      din_meta_reg <= din;
      din_s_reg    <= din_meta_reg;
      din_d_reg    <= din_s_reg;
      state_reg    <= state_next;
      div_cnt_reg  <= div_cnt_next;
      bit_cnt_reg  <= bit_cnt_next;
      shift_reg    <= shift_next;
      data_reg     <= data_next;
      vld_reg      <= vld_next;
`ifdef UART_RECV_FRAME_ERR_EN
      ferr_reg     <= ferr_next;
`endif
    end
  end

  always_comb begin
    state_next   = state_reg;
    div_cnt_next = div_cnt_reg + 10'd1;
    bit_cnt_next = bit_cnt_reg;
    shift_next   = shift_reg;
    data_next    = data_reg;
    vld_next     = 1'b0;
`ifdef UART_RECV_FRAME_ERR_EN
    ferr_next    = 1'b0;
`endif
    case (state_reg)
      IDLE: begin
        div_cnt_next = '0;
        // Only a high-to-low transition starts a frame; a line stuck low is ignored.
        if (!din_s_reg && din_d_reg) begin
          state_next = START;
        end
      end
      START: begin
        if (div_cnt_reg == HALF_C) begin
          div_cnt_next = '0;
          if (!din_s_reg) begin
            state_next   = DATA;
            bit_cnt_next = '0;
          end else begin
            state_next = IDLE;
          end
        end
      end
      DATA: begin
        if (div_cnt_reg == FULL_C) begin
          div_cnt_next = '0;
          shift_next   = {din_s_reg, shift_reg[7:1]};
          if (bit_cnt_reg == 3'd7) begin
            state_next = STOP;
          end else begin
            bit_cnt_next = bit_cnt_reg + 3'd1;
          end
        end
      end
      STOP: begin
        // Leaving at the stop-bit midpoint lets a back-to-back start edge be seen.
        if (div_cnt_reg == FULL_C) begin
          div_cnt_next = '0;
          state_next   = IDLE;
          if (din_s_reg) begin
            data_next = shift_reg;
            vld_next  = 1'b1;
          end else begin
`ifdef UART_RECV_FRAME_ERR_EN
            ferr_next = 1'b1;
`endif
          end
        end
      end
      default: begin
        state_next   = IDLE;
        div_cnt_next = '0;
      end
    endcase
  end

  assign din_vld  = vld_reg;
  assign din_data = data_reg;
`ifdef UART_RECV_FRAME_ERR_EN
  assign frame_err = ferr_reg;
`endif

endmodule

// File: tb/tb_uart_recv.sv
// Self-checking bench for uart_recv: a frame table, hand-written corner
// sequences, and randomized frames against a frame-level reference model.
module tb_uart_recv;

  // Shortened bit period (96 clocks) with the same half/full ratio as 868/434.
  localparam int FULL = 95;
  localparam int HALF = 47;
  localparam int P    = FULL + 1;
  localparam int LAT  = 3 + (HALF + 1) + 9 * (FULL + 1);

  logic       clk;
  logic       rst;
  logic       din;
  logic       din_vld;
  logic [7:0] din_data;
`ifdef UART_RECV_FRAME_ERR_EN
  logic       frame_err;
`endif

  uart_recv #(.FULL_T(FULL), .HALF_T(HALF)) dut (
    .clk      (clk),
    .rst      (rst),
    .din      (din),
    .din_vld  (din_vld),
    .din_data (din_data)
`ifdef UART_RECV_FRAME_ERR_EN
    ,
    .frame_err(frame_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [7:0] data;
  } ev_t;

  typedef struct {
    logic [7:0] b;
    int         period;
    bit         stop;
    int         low_after;
    int         gap;
    bit         exp_vld;
    logic [7:0] exp_data;
    bit         chk_lat;
    bit         chk_space;
  } vec_t;

  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;
  int   ferr_cnt = 0;
  int   last_ev_cyc = 0;
  logic prev_vld = 1'b0;
  logic prev_ferr = 1'b0;
  ev_t  ev_q[$];
  vec_t tbl[8];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp, input int tol);
    int diff;
    diff = act - exp;
    if (diff < 0) diff = -diff;
    n_total++;
    if (diff <= tol) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) tol %0d",
                  name, act, act, exp, exp, tol);
  endtask

  // Record every strobe and check the single-cycle / exclusivity properties.
  always @(negedge clk) begin
    if (din_vld) begin
      check("vld_one_cycle", int'(prev_vld), 0, 0);
      ev_q.push_back('{cyc, din_data});
    end
`ifdef UART_RECV_FRAME_ERR_EN
    if (frame_err) begin
      check("ferr_not_with_vld", int'(din_vld), 0, 0);
      check("ferr_one_cycle", int'(prev_ferr), 0, 0);
      ferr_cnt++;
    end
    prev_ferr = frame_err;
`endif
    prev_vld = din_vld;
  end

  task automatic run_frame(input logic [7:0] b, input int period, input bit stop,
                           input int low_after, input int gap, input bit exp_vld,
                           input logic [7:0] exp_data, input bit chk_lat,
                           input bit chk_space);
    int  start_cyc;
    int  got;
    int  ferr0;
    ev_t ev;
    ferr0     = ferr_cnt;
    start_cyc = cyc;
    din = 1'b0;
    repeat (period) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      din = b[i];
      repeat (period) @(negedge clk);
    end
    din = stop;
    repeat (period) @(negedge clk);
    if (low_after > 0) begin
      din = 1'b0;
      repeat (low_after) @(negedge clk);
    end
    din = 1'b1;
    repeat (gap) @(negedge clk);
    got = ev_q.size();
    check("vld_count", got, exp_vld ? 1 : 0, 0);
    if (got > 0) begin
      ev = ev_q.pop_front();
      check("vld_data", int'(ev.data), int'(exp_data), 0);
      if (chk_lat) check("latency", ev.cyc - start_cyc, LAT, 1);
      if (chk_space) check("b2b_spacing", ev.cyc - last_ev_cyc, 10 * period, 0);
      last_ev_cyc = ev.cyc;
    end
    ev_q.delete();
    check("din_data", int'(din_data), int'(exp_data), 0);
`ifdef UART_RECV_FRAME_ERR_EN
    check("frame_err_count", ferr_cnt - ferr0, stop ? 0 : 1, 0);
`endif
    $display("frame 0x%02h period %0d stop %0d -> din_data 0x%02h", b, period, stop, din_data);
  endtask

  initial begin
    logic [7:0] last_good;
    logic [7:0] rb;
    bit         rstop;
    int         rper;
    int         rgap;
    int         rlow;
    int         glen;

    tbl[0] = '{8'h55, P,  1'b1, 0,   200, 1'b1, 8'h55, 1'b1, 1'b0};
    tbl[1] = '{8'hA3, P,  1'b1, 0,   0,   1'b1, 8'hA3, 1'b1, 1'b0};
    tbl[2] = '{8'h0F, P,  1'b1, 0,   200, 1'b1, 8'h0F, 1'b1, 1'b1};
    tbl[3] = '{8'h12, P,  1'b1, 0,   200, 1'b1, 8'h12, 1'b1, 1'b0};
    tbl[4] = '{8'h3C, P,  1'b0, 220, 200, 1'b0, 8'h12, 1'b0, 1'b0};
    tbl[5] = '{8'h7E, P,  1'b1, 0,   200, 1'b1, 8'h7E, 1'b1, 1'b0};
    tbl[6] = '{8'hE7, 93, 1'b1, 0,   200, 1'b1, 8'hE7, 1'b0, 1'b0};
    tbl[7] = '{8'hE7, 99, 1'b1, 0,   200, 1'b1, 8'hE7, 1'b0, 1'b0};

    din = 1'b1;
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("reset_vld", int'(din_vld), 0, 0);
    check("reset_data", int'(din_data), 0, 0);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    check("idle_vld_count", ev_q.size(), 0, 0);
    $display("reset done: din_vld %0d din_data 0x%02h", din_vld, din_data);

    foreach (tbl[i])
      run_frame(tbl[i].b, tbl[i].period, tbl[i].stop, tbl[i].low_after, tbl[i].gap,
                tbl[i].exp_vld, tbl[i].exp_data, tbl[i].chk_lat, tbl[i].chk_space);

    // Short low glitch must be rejected at the start-bit midpoint.
    din = 1'b0;
    repeat (22) @(negedge clk);
    din = 1'b1;
    repeat (2300) @(negedge clk);
    check("glitch_vld_count", ev_q.size(), 0, 0);
    check("glitch_data", int'(din_data), 8'hE7, 0);
    $display("glitch: events %0d din_data 0x%02h", ev_q.size(), din_data);
    run_frame(8'hC6, P, 1'b1, 0, 200, 1'b1, 8'hC6, 1'b1, 1'b0);

    // Reset pulse during data bit 4 of 0xFF.
    fork
      run_frame(8'hFF, P, 1'b1, 0, 200, 1'b0, 8'h00, 1'b0, 1'b0);
      begin
        repeat (5 * P + 40) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
      end
    join
    run_frame(8'h81, P, 1'b1, 0, 200, 1'b1, 8'h81, 1'b1, 1'b0);

    // Random frames: a good stop bit delivers the byte, a bad one keeps the old byte.
    last_good = 8'h81;
    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        glen = $urandom_range(1, 40);
        din = 1'b0;
        repeat (glen) @(negedge clk);
        din = 1'b1;
        repeat (80) @(negedge clk);
      end
      rb    = 8'($urandom);
      rstop = ($urandom_range(0, 4) != 0);
      rper  = $urandom_range(93, 99);
      if (rstop) begin
        rlow = 0;
        rgap = $urandom_range(0, 100);
      end else begin
        rlow = $urandom_range(0, 100);
        rgap = $urandom_range(60, 200);
      end
      if (rstop) last_good = rb;
      run_frame(rb, rper, rstop, rlow, rgap, rstop, last_good, 1'b0, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
